// File: rtl/sram_bus_master.sv
// Initiator for the AVR<->SRAM strobe bus: one request becomes one timed cs/we/oe bus cycle.
// Optional macro SBM_AUTOINC_EN adds a sequential address pointer selected by req_seq.
module sram_bus_master #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned AWIDTH     = 16,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic              req_seq,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic [AWIDTH-1:0] bus_addr,
  inout  wire  [DWIDTH-1:0] bus_data,
  output logic              bus_cs_n,
  output logic              bus_we_n,
  output logic              bus_oe_n,
  output logic              busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              write_q, write_d;
  logic [AWIDTH-1:0] addr_d, use_addr;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rsp_rdata_d;
  logic              rsp_d, cs_n_d, we_n_d, oe_n_d, drive_q, drive_d, ready_d;
  logic              accept, last;

  assign accept = req_valid & req_ready;
  assign last   = (cnt == CW'(1));
  assign busy   = ~req_ready;
  assign bus_data = drive_q ? wdata_q : {DWIDTH{1'bz}};

`ifdef SBM_AUTOINC_EN
  logic [AWIDTH-1:0] addr_ptr;

  assign use_addr = req_seq ? addr_ptr : req_addr;

  // Pointer always advances past the address actually used, wrapping at 2^AWIDTH.
  always_ff @(posedge clk) begin
    if (reset)       addr_ptr <= '0;
    else if (accept) addr_ptr <= use_addr + AWIDTH'(1);
  end
`else
  logic unused_seq;

  assign use_addr   = req_addr;
  assign unused_seq = req_seq;
`endif

  // Next state plus next values of every registered output, decoded from state_d.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    write_d     = write_q;
    addr_d      = bus_addr;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_d       = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC);
          write_d = req_write;
          addr_d  = use_addr;
          wdata_d = req_wdata;
        end
      end
      S_SETUP: begin
        if (last) begin
          state_d = S_STROBE;
          cnt_d   = CW'(STROBE_CYC);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (last) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC);
          if (!write_q) rdata_d = bus_data;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (last) begin
          rsp_d   = 1'b1;
          cnt_d   = CW'(1);
          state_d = write_q ? S_IDLE : S_TURN;
          if (!write_q) rsp_rdata_d = rdata_q;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cs_n_d  = !(state_d inside {S_SETUP, S_STROBE, S_HOLD});
    we_n_d  = !((state_d == S_STROBE) && write_d);
    oe_n_d  = !((state_d == S_STROBE) && !write_d);
    drive_d = (state_d inside {S_SETUP, S_STROBE, S_HOLD}) && write_d;
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      bus_addr  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_cs_n  <= 1'b1;
      bus_we_n  <= 1'b1;
      bus_oe_n  <= 1'b1;
      drive_q   <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      write_q   <= write_d;
      bus_addr  <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rsp_valid <= rsp_d;
      rsp_rdata <= rsp_rdata_d;
      bus_cs_n  <= cs_n_d;
      bus_we_n  <= we_n_d;
      bus_oe_n  <= oe_n_d;
      drive_q   <= drive_d;
      req_ready <= ready_d;
    end
  end

endmodule
